uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
- Transmit-side byte buffer that sits directly upstream of uart_tx.
- Accepts bursts of bytes from a producer, such as uart_rx loopback or a future command/response engine, and stores them in a circular FIFO.
- Drains the FIFO one byte at a time into uart_tx using uart_tx's start/done handshake.
- Absorbs rate mismatch so producers never stall on the serial line rate.

Parameters:
- DATA_W, 8, byte width; must match uart_tx data width.
- ADDR_W, 4, FIFO address width; depth = 2**ADDR_W = 16 entries.

Ports:
- I_CLK  in  1  system clock (50 MHz). One clock; reset is asynchronous and active-high.
- I_RST  in  1  async reset, active-high.
- I_WR_EN  in  1  producer write strobe; one byte per cycle when high.
- I_WR_DATA  in  DATA_W  byte to enqueue.
- I_FLUSH  in  1  synchronous clear of queued bytes.
- I_TX_DONE  in  1  one-cycle pulse from uart_tx when the stop bit completes.
- O_TX_START  out  1  one-cycle pulse to uart_tx I_TX_START.
- O_TX_DATA  out  DATA_W  byte to uart_tx I_DATA; held stable from the start pulse until done.
- O_FULL  out  1  count == 2**ADDR_W.
- O_EMPTY  out  1  count == 0.
- O_COUNT  out  ADDR_W+1  number of queued bytes (0..16); excludes the byte currently in flight.
- O_OVERFLOW  out  1  one-cycle pulse when a write is dropped.

Behaviour:
- Reset values (async on I_RST high):
  - wr_ptr, rd_ptr, count = 0; state = IDLE.
  - O_TX_START = 0, O_TX_DATA = 0, O_OVERFLOW = 0, O_EMPTY = 1, O_FULL = 0.
  - Memory contents are don't-care.
- Pointers: ADDR_W bits each, natural wrap 15 -> 0. Count is a separate ADDR_W+1-bit register.
- Write rules:
  - I_WR_EN && !O_FULL: write mem[wr_ptr], increment wr_ptr.
  - I_WR_EN && O_FULL: byte dropped; O_OVERFLOW = 1 next cycle; pointers and count unchanged.
  - Full is evaluated on the registered count. A write on the same cycle as a pop while full is still dropped.
- Count arithmetic: +1 on accepted write, -1 on pop, unchanged when both occur in the same cycle.
- FSM, three states, all outputs registered:
  - IDLE: if !O_EMPTY, load O_TX_DATA <= mem[rd_ptr], increment rd_ptr, decrement count, go to START. Otherwise stay.
  - START: O_TX_START = 1 for exactly this cycle; go to WAIT.
  - WAIT: hold O_TX_DATA. On I_TX_DONE go to IDLE. I_TX_DONE in IDLE or START is ignored.
- Latency:
  - Write into an empty FIFO at cycle 0: O_EMPTY falls at cycle 1; O_TX_START is high at cycle 2.
  - Back-to-back bytes: I_TX_DONE at cycle n gives the next O_TX_START at cycle n+2.
- I_FLUSH:
  - Next cycle wr_ptr = rd_ptr = count = 0.
  - A byte already popped (START/WAIT) completes normally and is not aborted.
  - A write in the same cycle as I_FLUSH is discarded with no overflow.
  - Flush has priority over write and pop.
- Reset mid-transfer: FSM returns to IDLE immediately and O_TX_START is forced low. The uart_tx frame in progress is that block's concern; this block issues no further starts until bytes are written.
- No X on outputs after reset, even while the memory is uninitialised: O_TX_DATA is loaded only from written entries.

Decomposition:
- Shared package uart_pkg:
  - UART_DATA_W = 8.
  - FSM state encoding (IDLE = 2'd0, START = 2'd1, WAIT = 2'd2) as a typedef.
  - Baud divisor constant (26) for shared use with the baud generator.
- One sub-module: uart_fifo_mem, a simple dual-port register array (write port plus asynchronous read by address), parameterised by DATA_W/ADDR_W. Pointers, count and FSM stay in uart_tx_fifo.

Test Plan:
- Reset, then write 0x55 at cycle 0 -> O_EMPTY = 0 at cycle 1; O_TX_START pulse at cycle 2 with O_TX_DATA = 0x55; O_COUNT returns to 0; data held until a stub I_TX_DONE arrives 100 cycles later.
- Write 0x00..0x0F back-to-back with the transmitter stub returning I_TX_DONE 50 cycles after each start -> 16 starts in order 0x00..0x0F, each start exactly 2 cycles after the previous done, then O_EMPTY = 1 and FSM idle.
- With the stub never asserting done, write 17 bytes 0xA0..0xB0 -> 0xA0 in flight, 0xA1..0xB0 queued (O_COUNT = 16, O_FULL = 1); a further write of 0xC0 gives one O_OVERFLOW pulse and 0xC0 is never transmitted.
- Write 20 bytes while draining to force pointer wrap past 15 -> output order matches input order exactly; no duplicates or losses.
- Queue 5 bytes with byte 0 in WAIT, assert I_FLUSH together with a write of 0x77 -> O_COUNT = 0 next cycle; only byte 0 completes; 0x77 is never sent.
- Assert I_RST while in START -> O_TX_START = 0 in the same cycle, O_EMPTY = 1, O_COUNT = 0; after release, no O_TX_START until a new write.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, transmit FSM encoding, baud divisor,
// and a small helper for FIFO sizing.
package uart_pkg;

    // Byte width shared by uart_tx, uart_rx and the transmit FIFO.
    localparam int UART_DATA_W = 8;

    // Clock divisor used by the baud generator (50 MHz system clock).
    localparam int UART_BAUD_DIV = 26;

    // Transmit FIFO drain FSM. WAIT covers the whole serial frame.
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_WAIT  = 2'd2
    } tx_state_t;

    // Number of entries in a FIFO addressed by addr_w bits.
    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port register array: one synchronous write port and one
// asynchronous read port, each addressed independently.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int ADDR_W = 4
) (
    input  logic              I_CLK,
    input  logic              I_WR_EN,
    input  logic [ADDR_W-1:0] I_WR_ADDR,
    input  logic [DATA_W-1:0] I_WR_DATA,
    input  logic [ADDR_W-1:0] I_RD_ADDR,
    output logic [DATA_W-1:0] O_RD_DATA
);

    logic [DATA_W-1:0] mem [fifo_depth(ADDR_W)];

    // Store the incoming byte at the write address.
    // NOTE: the array has no reset on purpose; every location is written
    // before it is read, so clearing it would only add reset fan-out.
    always_ff @(posedge I_CLK) begin
        if (I_WR_EN) begin
            mem[I_WR_ADDR] <= I_WR_DATA;
        end
    end

    assign O_RD_DATA = mem[I_RD_ADDR];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit-side byte buffer for uart_tx. Producers push bytes in bursts;
// the FSM pops one byte at a time and hands it to uart_tx through the
// start/done handshake, holding the byte on O_TX_DATA for the whole frame.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int ADDR_W = 4
) (
    input  logic              I_CLK,
    input  logic              I_RST,
    input  logic              I_WR_EN,
    input  logic [DATA_W-1:0] I_WR_DATA,
    input  logic              I_FLUSH,
    input  logic              I_TX_DONE,
    output logic              O_TX_START,
    output logic [DATA_W-1:0] O_TX_DATA,
    output logic              O_FULL,
    output logic              O_EMPTY,
    output logic [ADDR_W:0]   O_COUNT,
    output logic              O_OVERFLOW
);

    localparam logic [ADDR_W:0] DEPTH     = (ADDR_W+1)'(fifo_depth(ADDR_W));
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);

    tx_state_t         state;
    tx_state_t         next_state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [DATA_W-1:0] rd_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              wr_accept;
    logic              wr_drop;
    logic              pop;
    logic              start_nxt;

    // Full/empty come from the registered count, so a pop in the same
    // cycle never frees room for a write that arrives while full.
    assign fifo_full  = (count == DEPTH);
    assign fifo_empty = (count == '0);

    // Flush wins over both write and pop; a write during flush is simply
    // discarded and is not reported as an overflow.
    assign wr_accept = I_WR_EN && !fifo_full && !I_FLUSH;
    assign wr_drop   = I_WR_EN &&  fifo_full && !I_FLUSH;
    assign pop       = (state == TX_IDLE) && !fifo_empty && !I_FLUSH;

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .I_CLK     (I_CLK),
        .I_WR_EN   (wr_accept),
        .I_WR_ADDR (wr_ptr),
        .I_WR_DATA (I_WR_DATA),
        .I_RD_ADDR (rd_ptr),
        .O_RD_DATA (rd_data)
    );

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (I_FLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_accept, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Drain FSM state register.
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state <= TX_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Drain FSM next-state: pop in IDLE, pulse in START, wait for done.
    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            TX_IDLE: begin
                if (pop) begin
                    next_state = TX_START;
                end
            end
            TX_START: begin
                next_state = TX_WAIT;
            end
            TX_WAIT: begin
                if (I_TX_DONE) begin
                    next_state = TX_IDLE;
                end
            end
            default: begin
                next_state = TX_IDLE;
            end
        endcase
    end

    // Drain FSM output decode: the start pulse is registered, so it is
    // raised on the edge that enters START and dropped on the one leaving.
    always_comb begin
        start_nxt = (next_state == TX_START);
    end

    // Registered handshake outputs. O_TX_DATA only loads on a pop, which
    // needs a non-zero count, so it never picks up an unwritten entry.
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            O_TX_START <= 1'b0;
            O_TX_DATA  <= '0;
            O_OVERFLOW <= 1'b0;
        end else begin
            O_TX_START <= start_nxt;
            O_OVERFLOW <= wr_drop;
            if (pop) begin
                O_TX_DATA <= rd_data;
            end
        end
    end

    assign O_FULL  = fifo_full;
    assign O_EMPTY = fifo_empty;
    assign O_COUNT = count;

endmodule
